// File: rtl/odd_ticks_pkg.sv
// Shared constants and types for the odd_ticks parity generator.
package odd_ticks_pkg;

   localparam logic        ODD_TICKS_RST_VAL    = 1'b0;
   localparam int unsigned ODD_TICKS_TICK_W_DEF = 8;

   typedef logic [ODD_TICKS_TICK_W_DEF-1:0] tick_t;

endpackage

// File: rtl/tick_counter.sv
// Free-running wrapping up-counter with asynchronous active-high reset to zero.
module tick_counter
   import odd_ticks_pkg::*;
#(
   parameter int unsigned WIDTH = ODD_TICKS_TICK_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] count
);

   // Wrap from all-ones to zero falls out of the modulo-2^WIDTH add.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/odd_ticks.sv
// Registered half-rate square wave: o_data is the parity of ticks since reset.
module odd_ticks
   import odd_ticks_pkg::*;
#(
   parameter int unsigned TICK_W  = ODD_TICKS_TICK_W_DEF,
   parameter logic        RST_VAL = ODD_TICKS_RST_VAL
) (
   input  logic clk,
   input  logic rst,
   output logic o_data
);

   logic [TICK_W-1:0] tick_q;
   logic              par_q;

   tick_counter #(
      .WIDTH (TICK_W)
   ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .count (tick_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_q <= RST_VAL;
      end else begin
         par_q <= ~par_q;
      end
   end

   assign o_data = par_q;

   // The toggle flop must track the counter's low bit for the whole run.
   a_parity : assert property (@(posedge clk) disable iff (rst)
      par_q == (tick_q[0] ^ RST_VAL));

   a_zero_tick : assert property (@(posedge clk) disable iff (rst)
      (tick_q == '0) |-> (par_q == RST_VAL));

endmodule

// File: tb/tb_odd_ticks.sv
// Self-checking bench for odd_ticks: vector table, reset corner cases, random reset pulses.
module tb_odd_ticks;

   logic clk;
   logic rst;
   logic o_def;
   logic o_w2;
   logic o_rv1;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: number of unreset rising edges since the last reset.
   int  n_edges     = 0;
   bit  prev_rst    = 1'b1;
   bit  prev_unrst  = 1'b0;
   logic prev_o     = 1'b0;

   typedef struct {
      bit r;
      bit o_def;
      bit o_rv1;
      int t_def;
      int t_w2;
   } vec_t;

   vec_t tbl [14];

   odd_ticks u_def (
      .clk    (clk),
      .rst    (rst),
      .o_data (o_def)
   );

   odd_ticks #(
      .TICK_W (2)
   ) u_w2 (
      .clk    (clk),
      .rst    (rst),
      .o_data (o_w2)
   );

   odd_ticks #(
      .RST_VAL (1'b1)
   ) u_rv1 (
      .clk    (clk),
      .rst    (rst),
      .o_data (o_rv1)
   );

   initial begin
      clk = 1'b0;
      forever #2 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Called at a falling edge (or time 0): applies r, crosses one rising edge,
   // then samples at the next falling edge.
   task automatic step(input bit r, input bit mdl);
      rst = r;
      if (r && !prev_rst) begin
         #1;
         chk("async_def_o", {31'b0, o_def}, 32'd0);
         chk("async_rv1_o", {31'b0, o_rv1}, 32'd1);
         chk("async_def_tick", {24'b0, u_def.u_cnt.count}, 32'd0);
      end
      prev_rst = r;
      @(posedge clk);
      if (r) n_edges = 0;
      else   n_edges = n_edges + 1;
      @(negedge clk);
      if (mdl) begin
         chk("mdl_def_o",   {31'b0, o_def},  32'(n_edges % 2));
         chk("mdl_w2_o",    {31'b0, o_w2},   32'(n_edges % 2));
         chk("mdl_rv1_o",   {31'b0, o_rv1},  32'(1 - (n_edges % 2)));
         chk("mdl_def_tick", {24'b0, u_def.u_cnt.count}, 32'(n_edges % 256));
         chk("mdl_w2_tick",  {30'b0, u_w2.u_cnt.count},  32'(n_edges % 4));
         if (!r && prev_unrst) begin
            chk("alternate", {31'b0, o_def}, {31'b0, ~prev_o});
         end
      end
      prev_o     = o_def;
      prev_unrst = !r;
   endtask

   initial begin
      rst = 1'b1;

      // Reset held for 4 edges, then 10 free edges: W=2 counter wraps twice.
      tbl = '{
         '{1'b1, 1'b0, 1'b1,  0, 0},
         '{1'b1, 1'b0, 1'b1,  0, 0},
         '{1'b1, 1'b0, 1'b1,  0, 0},
         '{1'b1, 1'b0, 1'b1,  0, 0},
         '{1'b0, 1'b1, 1'b0,  1, 1},
         '{1'b0, 1'b0, 1'b1,  2, 2},
         '{1'b0, 1'b1, 1'b0,  3, 3},
         '{1'b0, 1'b0, 1'b1,  4, 0},
         '{1'b0, 1'b1, 1'b0,  5, 1},
         '{1'b0, 1'b0, 1'b1,  6, 2},
         '{1'b0, 1'b1, 1'b0,  7, 3},
         '{1'b0, 1'b0, 1'b1,  8, 0},
         '{1'b0, 1'b1, 1'b0,  9, 1},
         '{1'b0, 1'b0, 1'b1, 10, 2}
      };

      for (int i = 0; i < 14; i++) begin
         step(tbl[i].r, 1'b0);
         chk($sformatf("tbl%0d_def_o", i),   {31'b0, o_def}, {31'b0, tbl[i].o_def});
         chk($sformatf("tbl%0d_w2_o", i),    {31'b0, o_w2},  {31'b0, tbl[i].o_def});
         chk($sformatf("tbl%0d_rv1_o", i),   {31'b0, o_rv1}, {31'b0, tbl[i].o_rv1});
         chk($sformatf("tbl%0d_def_tick", i), {24'b0, u_def.u_cnt.count}, 32'(tbl[i].t_def));
         chk($sformatf("tbl%0d_w2_tick", i),  {30'b0, u_w2.u_cnt.count},  32'(tbl[i].t_w2));
      end

      // Mid-cycle asynchronous reset while o_data is high, then recovery.
      step(1'b0, 1'b1);
      chk("pre_async_high", {31'b0, o_def}, 32'd1);
      step(1'b1, 1'b1);
      chk("in_reset_low", {31'b0, o_def}, 32'd0);
      step(1'b0, 1'b1);
      chk("post_reset_first", {31'b0, o_def}, 32'd1);
      chk("post_reset_rv1", {31'b0, o_rv1}, 32'd0);

      // Long unreset run so the default 8-bit counter wraps too.
      step(1'b1, 1'b1);
      for (int i = 0; i < 300; i++) begin
         step(1'b0, 1'b1);
      end

      // Random reset pulses against the model.
      for (int i = 0; i < 1000; i++) begin
         step(($urandom_range(0, 9) == 0), 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
